// File: rtl/noc_pkg.sv
// Shared NoC router constants and packet/port types used by the arbiter
// receive path (packet_distributor and its test environment).
package noc_pkg;

  localparam int PL   = 8;
  localparam int REN  = 5;
  localparam int IDXW = 4;

  typedef logic [PL-1:0]   packet_t;
  typedef logic [IDXW-1:0] port_idx_t;

endpackage

// File: rtl/lane_fifo.sv
// Single-clock synchronous FIFO for one output lane: push at the tail, pop at
// the head, occupancy tracked by an explicit count (full/empty derived from it).
module lane_fifo #(
  parameter int DEPTH = 4,
  parameter int PL    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [PL-1:0]              push_data,
  input  logic                       pop,
  output logic [PL-1:0]              head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PL-1:0] mem_q [DEPTH];
  logic [PL-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // An empty lane presents zero rather than stale storage contents.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/packet_distributor.sv
// Arbiter receive end: steers each packet to the lane named by in_shift, drops
// out-of-range indices. Optional null-packet discard: PACKET_DISTRIBUTOR_NULL_FILTER_EN.
module packet_distributor #(
  parameter int PL    = 8,
  parameter int REN   = 5,
  parameter int DEPTH = 4,
  parameter int IDXW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PL-1:0]       in_data,
  input  logic [IDXW-1:0]     in_shift,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [REN*PL-1:0]   out_data,
  output logic [REN-1:0]      out_valid,
  input  logic [REN-1:0]      out_ready,
  output logic                drop_pulse
);

  import noc_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [IDXW-1:0] REN_IDX = IDXW'(REN);

  logic [REN-1:0]    lane_full;
  logic [REN-1:0]    lane_empty;
  logic [REN-1:0]    lane_push;
  logic [REN-1:0]    lane_pop;
  logic [CW-1:0]     lane_count [REN];
  logic [REN*PL-1:0] head_bus;
  logic              in_range;
  logic              sel_full;
  logic              is_null;
  logic              accept;
  logic              drop_q, drop_d;

`ifdef PACKET_DISTRIBUTOR_NULL_FILTER_EN
  assign is_null = (in_data == '0);
`else
  assign is_null = 1'b0;
`endif

  assign in_range = (in_shift < REN_IDX);

  // Ready is a pure function of registered occupancy and the index; no out_ready path.
  always_comb begin
    sel_full = 1'b0;
    for (int k = 0; k < REN; k++) begin
      if (in_shift == IDXW'(k)) sel_full = lane_full[k];
    end
  end

  assign in_ready = is_null || !in_range || !sel_full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    lane_push = '0;
    for (int k = 0; k < REN; k++) begin
      lane_push[k] = accept && in_range && !is_null && (in_shift == IDXW'(k));
    end
  end

  assign lane_pop = out_ready & ~lane_empty;
  assign drop_d   = accept && !in_range && !is_null;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= 1'b0;
    else        drop_q <= drop_d;
  end

  assign drop_pulse = drop_q;

  for (genvar g = 0; g < REN; g++) begin : g_lane
    lane_fifo #(
      .DEPTH (DEPTH),
      .PL    (PL)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (lane_push[g]),
      .push_data (in_data),
      .pop       (lane_pop[g]),
      .head      (head_bus[g*PL +: PL]),
      .count     (lane_count[g]),
      .full      (lane_full[g]),
      .empty     (lane_empty[g])
    );
    assign out_valid[g] = (lane_count[g] != '0);
  end

  assign out_data = head_bus;

endmodule
